// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: select bit positions, FSM
// state encodings and the divider iteration-counter width helper.
package alu_pkg;

  // Bit positions within the one-hot select vector.
  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_SHR = 2;
  localparam int unsigned ALU_SHL = 3;
  localparam int unsigned ALU_ROR = 4;
  localparam int unsigned ALU_ROL = 5;
  localparam int unsigned ALU_AND = 6;
  localparam int unsigned ALU_OR  = 7;
  localparam int unsigned ALU_MUL = 8;
  localparam int unsigned ALU_DIV = 9;
  localparam int unsigned ALU_NEG = 10;
  localparam int unsigned ALU_NOT = 11;

  localparam int unsigned ALU_NUM_OPS = 12;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIV_RUN = 2'd1,
    S_DIV_FIX = 2'd2
  } alu_state_e;

  // Counter holds 0 .. width-1, so $clog2(width) bits are enough.
  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sequential_divider.sv
// Unsigned restoring divider, one quotient bit per step. The caller loads
// magnitudes and handles signs; done flags the step producing the last bit.
module sequential_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  // Load operands or perform one shift/trial-subtract iteration.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      // A borrow (msb set) means the divisor did not fit: restore.
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign done      = step && (cnt_q == CNT_W'(WIDTH - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with start/done handshake. Everything except division
// completes in one cycle; division runs WIDTH steps plus one sign-fix step.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ALU_NUM_OPS-1:0] select,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       z,
  output logic [WIDTH-1:0]       hi,
  output logic [WIDTH-1:0]       lo,
  output logic                   div_by_zero
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  alu_state_e state_q, state_d;
  logic [WIDTH-1:0] z_q, z_d, hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dbz_q, dbz_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic             div_load, div_step, div_last;
  logic [WIDTH-1:0] div_quo, div_rem, abs_a, abs_b;
  logic [2*WIDTH-1:0] prod, ror_full, rol_full;
  logic [CNT_W-1:0] rot_amt;

  // Most-negative operand maps to itself, which reads correctly as unsigned.
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  // Sign-extended to full width so the low 2*WIDTH bits are the signed product.
  assign prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

  assign rot_amt  = CNT_W'(b % WIDTH);
  assign ror_full = {a, a} >> rot_amt;
  assign rol_full = {a, a} << rot_amt;

  sequential_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_last)
  );

  // Next-state, result and divider control decode.
  always_comb begin
    state_d  = state_q;
    z_d      = z_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    div_load = 1'b0;
    div_step = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d  = 1'b0;
          done_d = 1'b1;
          if (!$onehot(select)) begin
            z_d = '0;
          end else begin
            unique case (1'b1)
              select[ALU_ADD]: z_d = a + b;
              select[ALU_SUB]: z_d = a - b;
              select[ALU_SHR]: z_d = a >> b;
              select[ALU_SHL]: z_d = a << b;
              select[ALU_ROR]: z_d = ror_full[WIDTH-1:0];
              select[ALU_ROL]: z_d = rol_full[2*WIDTH-1:WIDTH];
              select[ALU_AND]: z_d = a & b;
              select[ALU_OR]:  z_d = a | b;
              select[ALU_MUL]: {hi_d, lo_d} = prod;
              select[ALU_DIV]: begin
                if (b == '0) begin
                  lo_d  = '1;
                  hi_d  = a;
                  dbz_d = 1'b1;
                end else begin
                  done_d   = 1'b0;
                  div_load = 1'b1;
                  q_neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
                  r_neg_d  = a[WIDTH-1];
                  state_d  = S_DIV_RUN;
                end
              end
              select[ALU_NEG]: z_d = -a;
              select[ALU_NOT]: z_d = ~a;
              default: z_d = '0;
            endcase
          end
        end
      end
      S_DIV_RUN: begin
        div_step = 1'b1;
        if (div_last) state_d = S_DIV_FIX;
      end
      S_DIV_FIX: begin
        // Quotient truncates toward zero; remainder follows the dividend.
        lo_d    = q_neg_q ? -div_quo : div_quo;
        hi_d    = r_neg_q ? -div_rem : div_rem;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign z           = z_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle at WIDTH = 32.
module tb_alu_multicycle;

  localparam int unsigned W = 32;

  localparam logic [11:0] OP_ADD = 12'h001;
  localparam logic [11:0] OP_SUB = 12'h002;
  localparam logic [11:0] OP_SHR = 12'h004;
  localparam logic [11:0] OP_SHL = 12'h008;
  localparam logic [11:0] OP_ROR = 12'h010;
  localparam logic [11:0] OP_ROL = 12'h020;
  localparam logic [11:0] OP_AND = 12'h040;
  localparam logic [11:0] OP_OR  = 12'h080;
  localparam logic [11:0] OP_MUL = 12'h100;
  localparam logic [11:0] OP_DIV = 12'h200;
  localparam logic [11:0] OP_NEG = 12'h400;
  localparam logic [11:0] OP_NOT = 12'h800;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [11:0]   select = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  z, hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  alu_multicycle #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .select      (select),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .z           (z),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request before an edge; return at that edge + 1.
  task automatic issue(input logic [11:0] sel, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start  = 1'b1;
    select = sel;
    a      = x;
    b      = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; counts edges waited and busy samples seen.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (!done && lat < 100) begin
      busy_cycles += int'(busy);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bc, lat2;
    logic saw_done;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_z", z, 32'h0);
    check_eq("rst_hi", hi, 32'h0);
    check_eq("rst_lo", lo, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_dbz", 32'(div_by_zero), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    issue(OP_ADD, 32'd124, 32'd7);
    check_eq("add_z", z, 32'd131);
    check_eq("add_done", 32'(done), 32'h1);
    check_eq("add_busy", 32'(busy), 32'h0);
    issue(OP_SUB, 32'd124, 32'd7);
    check_eq("sub_z", z, 32'd117);
    check_eq("sub_done", 32'(done), 32'h1);
    issue(OP_AND, 32'd124, 32'd7);
    check_eq("and_z", z, 32'h04);
    issue(OP_OR, 32'd124, 32'd7);
    check_eq("or_z", z, 32'h7F);

    issue(OP_SHR, 32'h8000_0000, 32'd4);
    check_eq("shr_z", z, 32'h0800_0000);
    issue(OP_SHL, 32'h7C, 32'd7);
    check_eq("shl_z", z, 32'h3E00);
    issue(OP_SHL, 32'h7C, 32'd40);
    check_eq("shl40_z", z, 32'h0);
    issue(OP_ROR, 32'h7C, 32'd4);
    check_eq("ror_z", z, 32'hC000_0007);
    issue(OP_ROL, 32'h8000_0001, 32'd33);
    check_eq("rol_z", z, 32'h0000_0003);

    issue(OP_MUL, 32'd124, 32'd7);
    check_eq("mul_lo", lo, 32'd868);
    check_eq("mul_hi", hi, 32'h0);
    check_eq("mul_z_hold", z, 32'h3);
    issue(OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("mulmin_lo", lo, 32'h8000_0000);
    check_eq("mulmin_hi", hi, 32'h0);
    check_eq("mulmin_z_hold", z, 32'h3);

    issue(OP_NEG, 32'd5, 32'd0);
    check_eq("neg_z", z, 32'hFFFF_FFFB);
    check_eq("neg_hi_hold", hi, 32'h0);
    issue(OP_NEG, 32'h8000_0000, 32'd0);
    check_eq("negmin_z", z, 32'h8000_0000);
    issue(OP_NOT, 32'h0F0F_0000, 32'd0);
    check_eq("not_z", z, 32'hF0F0_FFFF);

    issue(12'h000, 32'd9, 32'd9);
    check_eq("noop0_z", z, 32'h0);
    check_eq("noop0_done", 32'(done), 32'h1);
    check_eq("noop0_lo_hold", lo, 32'h8000_0000);
    issue(OP_ADD, 32'd1, 32'd1);
    issue(12'h003, 32'd9, 32'd9);
    check_eq("noopmh_z", z, 32'h0);
    check_eq("noopmh_done", 32'(done), 32'h1);

    // -7 / 2
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check_eq("div_busy_start", 32'(busy), 32'h1);
    check_eq("div_done_start", 32'(done), 32'h0);
    wait_done(lat, bc);
    check_eq("div_latency", 32'(lat), 32'd33);
    check_eq("div_busy_cycles", 32'(bc), 32'd33);
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);
    check_eq("div_busy_end", 32'(busy), 32'h0);
    check_eq("div_dbz", 32'(div_by_zero), 32'h0);

    // New request accepted in the done cycle.
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    check_eq("divmin_lat", 32'(lat), 32'd33);
    check_eq("divmin_lo", lo, 32'h8000_0000);
    check_eq("divmin_hi", hi, 32'h0);

    issue(OP_DIV, 32'd5, 32'd0);
    check_eq("dbz_lo", lo, 32'hFFFF_FFFF);
    check_eq("dbz_hi", hi, 32'd5);
    check_eq("dbz_flag", 32'(div_by_zero), 32'h1);
    check_eq("dbz_done", 32'(done), 32'h1);
    check_eq("dbz_busy", 32'(busy), 32'h0);
    issue(OP_ADD, 32'd1, 32'd2);
    check_eq("dbz_clear", 32'(div_by_zero), 32'h0);
    check_eq("dbz_add_z", z, 32'd3);

    // 100 / 7 with an add request at cycle 5 that must be ignored.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    issue(OP_ADD, 32'd1, 32'd1);
    wait_done(lat2, bc);
    check_eq("ign_lat", 32'(lat2 + 5), 32'd33);
    check_eq("ign_lo", lo, 32'd14);
    check_eq("ign_hi", hi, 32'd2);
    check_eq("ign_z_hold", z, 32'd3);

    // Reset at cycle 10 of a division.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("mrst_z", z, 32'h0);
    check_eq("mrst_hi", hi, 32'h0);
    check_eq("mrst_lo", lo, 32'h0);
    check_eq("mrst_busy", 32'(busy), 32'h0);
    check_eq("mrst_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    check_eq("mrst_no_done", 32'(saw_done), 32'h0);
    issue(OP_ADD, 32'd124, 32'd7);
    check_eq("post_rst_add", z, 32'd131);
    check_eq("post_rst_done", 32'(done), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered ALU with a start/done handshake. It replaces the purely combinational datapath ALU. All twelve one-hot operations are implemented, including shift right, rotate right/left, and a sequential signed divider that writes HI/LO. Results are held in output registers until the next completed operation. It sits between the register-file read ports and the Z/HI/LO write-back path, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, 32, operand/result width; even, ≥ 4.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while idle.
- `select`  in  12  one-hot op: bit0 add, 1 sub, 2 shr, 3 shl, 4 ror, 5 rol, 6 and, 7 or, 8 mul, 9 div, 10 neg, 11 not.
- `a`, `b`  in  WIDTH  operands; sampled on the start edge only.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  one-cycle pulse when results land.
- `z`  out  WIDTH  result for all ops except mul/div.
- `hi`, `lo`  out  WIDTH  mul: product {hi,lo}; div: hi = remainder, lo = quotient.
- `div_by_zero`  out  1  set by a div with b = 0; cleared by the next accepted start.

## Operation
- States:
  - IDLE: accepts `start`.
  - DIV_RUN: WIDTH iterations.
  - DIV_FIX: applies signs, writes hi/lo.
- From IDLE, `start` with select:
  - Single-cycle op: registers the result and pulses `done`; stays in IDLE.
  - div with b ≠ 0: latches |a|, |b| and the operand signs, clears the iteration counter, goes to DIV_RUN.
  - div with b = 0: single-cycle. Sets lo = all ones, hi = a, `div_by_zero` = 1.
- Add/sub: modulo 2^WIDTH; carry discarded.
- shr is logical and shl zero-fills. Both use the full `b`; b ≥ WIDTH gives 0.
- ror/rol rotate by b mod WIDTH.
- and/or: bitwise. neg: two's complement of a (most-negative maps to itself). not: ~a.
- mul: signed WIDTH×WIDTH → 2·WIDTH product; single-cycle combinational multiplier, registered.
- div: signed, truncating toward zero; remainder takes the dividend's sign. Most-negative / −1 gives lo = most-negative, hi = 0.
- `z` is written only by non-mul/div ops. `hi`/`lo` are written only by mul/div. Unwritten outputs hold.
- Zero or multi-hot `select` with `start`: no-op. z = 0, hi/lo hold, `done` pulses.
- `start` while busy is ignored; it is not queued.

## Timing
- Reset: state IDLE; z, hi, lo = 0; busy, done, div_by_zero = 0. Asserting reset mid-division aborts it; no `done` is produced.
- Single-cycle ops:
  - `start` is sampled at edge E.
  - Results and `done` are visible after E; busy stays 0.
  - Back-to-back starts every cycle are legal.
- Division:
  - Start at edge E → DIV_RUN.
  - Edges E+1 … E+WIDTH each produce one quotient bit → DIV_FIX.
  - Edge E+WIDTH+1: hi/lo written, `done` = 1, busy = 0, state IDLE.
  - Latency is WIDTH+1 cycles; busy is high for exactly WIDTH+1 cycles.
  - A new `start` is accepted on the cycle `done` is high.
- Operand changes after the start edge have no effect.

## Structure
- Shared package `alu_pkg`:
  - select bit indices ALU_ADD … ALU_NOT (0–11);
  - state encodings S_IDLE, S_DIV_RUN, S_DIV_FIX;
  - $clog2(WIDTH)-derived counter width.
- Sub-module `sequential_divider`, parametrised by WIDTH:
  - unsigned restoring divider core with load/step/done;
  - sign handling stays in the top.
- Remaining combinational ops are inline in the top.

## Test plan
- WIDTH=32, a=124, b=7, add → z=131, done 1 cycle after start. Then sub → z=117. Then and → z=0x04. Then or → z=0x7F.
- Shifts/rotates:
  - shr 0x80000000 by 4 → 0x08000000.
  - shl 0x7C by 7 → 0x3E00.
  - shl by 40 → 0.
  - ror 0x7C by 4 → 0xC0000007.
  - rol 0x80000001 by 33 → 0x00000003.
- mul a=124, b=7 → lo=868, hi=0. mul 0x80000000 × 0xFFFFFFFF → hi=0, lo=0x80000000. z unchanged in both.
- Division:
  - div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy for 33 cycles, done at start+33.
  - 0x80000000/−1 → lo=0x80000000, hi=0.
- div 5/0 → lo=0xFFFFFFFF, hi=5, div_by_zero=1, done next cycle. A following add clears div_by_zero.
- During a division:
  - `start` with add at cycle 5 → ignored; the div result is unaffected.
  - reset_n low at cycle 10 → all outputs 0, busy=0, no done.
  - add issued after reset → correct.
